shift_rot_engine: RTL and testbench

- Parametrised, clocked successor to the ALSU combinational 6-bit shift/rotate stage.
- Loads a WIDTH-bit word and applies a multi-bit shift, rotate or arithmetic shift, one bit position per clock.
- Uses a start/busy/done handshake.
- Sits after the ALSU operand muxes. It replaces the single-step shifter when shift amounts greater than 1 are needed.

---
 rtl/shift_rot_pkg.sv | 20 ++
 rtl/shift_rot_step.sv | 34 +++
 rtl/shift_rot_engine.sv | 90 +++++++++
 tb/tb_shift_rot_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_rot_pkg.sv
// Shared types and constants for the multi-cycle shift/rotate engine.
package shift_rot_pkg;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    ROTATE = 2'd1,
    ARITH  = 2'd2,
    RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_rot_step.sv
// Combinational single-position shift/rotate/arithmetic step.
// The reserved mode passes the word through; the caller decides whether to commit it.
module shift_rot_step
  import shift_rot_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_d,
  input  mode_e            i_mode,
  input  logic             i_direction,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_d,
  output logic             o_out
);

  always_comb begin
    o_d   = i_d;
    o_out = (i_direction == DIR_LEFT) ? i_d[WIDTH-1] : i_d[0];
    case (i_mode)
      SHIFT:
        o_d = (i_direction == DIR_LEFT) ? {i_d[WIDTH-2:0], i_serial_in}
                                        : {i_serial_in, i_d[WIDTH-1:1]};
      ROTATE:
        o_d = (i_direction == DIR_LEFT) ? {i_d[WIDTH-2:0], i_d[WIDTH-1]}
                                        : {i_d[0], i_d[WIDTH-1:1]};
      ARITH:
        o_d = (i_direction == DIR_LEFT) ? {i_d[WIDTH-2:0], 1'b0}
                                        : {i_d[WIDTH-1], i_d[WIDTH-1:1]};
      default:
        o_d = i_d;
    endcase
  end

endmodule

// File: rtl/shift_rot_engine.sv
// Multi-cycle shifter: loads a word, then applies one single-bit step per clock
// for the requested amount, with a start/busy/done handshake.
module shift_rot_engine
  import shift_rot_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] datain,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             direction,
  input  logic             serial_in,
  output logic [WIDTH-1:0] dataout,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_nextState;
  logic [AMT_W-1:0] r_count;
  mode_e            r_mode;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;
  logic             r_sout;
  logic [WIDTH-1:0] w_stepData;
  logic             w_stepOut;

  shift_rot_step #(.WIDTH(WIDTH)) u_step (
    .i_d         (r_data),
    .i_mode      (r_mode),
    .i_direction (r_dir),
    .i_serial_in (serial_in),
    .o_d         (w_stepData),
    .o_out       (w_stepOut)
  );

  // The step that takes the counter from 1 to 0 is the last one, so DONE follows it directly.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = (amount == '0) ? DONE : RUN;
      RUN:     if (r_count == AMT_W'(1)) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_mode  <= SHIFT;
      r_dir   <= DIR_RIGHT;
      r_data  <= '0;
      r_sout  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_data  <= datain;
            r_count <= amount;
            r_mode  <= mode_e'(mode);
            r_dir   <= direction;
          end
        end
        RUN: begin
          r_count <= r_count - AMT_W'(1);
          // Reserved mode still burns the cycles so latency does not depend on mode.
          if (r_mode != RSVD) begin
            r_data <= w_stepData;
            r_sout <= w_stepOut;
          end
        end
        default: ;
      endcase
    end
  end

  assign dataout    = r_data;
  assign serial_out = r_sout;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_shift_rot_engine.sv
// Self-checking bench for shift_rot_engine (WIDTH=6, AMT_W=3): directed cases
// plus random operations compared against an arithmetic reference model.
module tb_shift_rot_engine;
  import shift_rot_pkg::*;

  localparam int W = 6;
  localparam int M = 64;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] datain;
  logic [2:0] amount;
  logic [1:0] mode;
  logic       direction;
  logic       serial_in;
  logic [5:0] dataout;
  logic       serial_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int expSout = 0;

  shift_rot_engine #(.WIDTH(W), .AMT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .datain     (datain),
    .amount     (amount),
    .mode       (mode),
    .direction  (direction),
    .serial_in  (serial_in),
    .dataout    (dataout),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word treated as an integer in [0, 64): left = *2 mod 64, right = /2, top bit weight 32.
  task automatic refModel(input int dIn, input int amt, input int md, input int dir,
                          input logic [7:0] sBits, inout int sout, output int res);
    int d;
    int top;
    int low;
    d = dIn;
    for (int i = 0; i < amt; i++) begin
      top = d / H;
      low = d % 2;
      if (md != 3) sout = (dir == 1) ? top : low;
      case (md)
        0: d = (dir == 1) ? ((d * 2) % M + int'(sBits[i])) : (d / 2 + int'(sBits[i]) * H);
        1: d = (dir == 1) ? ((d * 2) % M + top) : (d / 2 + low * H);
        2: d = (dir == 1) ? ((d * 2) % M) : (d / 2 + top * H);
        default: ;
      endcase
    end
    res = d;
  endtask

  task automatic applyStimulus(input int d, input int amt, input int md, input int dir,
                               input logic [7:0] sBits, input bit glitch);
    int expD;
    refModel(d, amt, md, dir, sBits, expSout, expD);
    start     = 1'b1;
    datain    = d[5:0];
    amount    = amt[2:0];
    mode      = md[1:0];
    direction = dir[0];
    serial_in = sBits[0];
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= amt + 1; c++) begin
      serial_in = sBits[c-1];
      if (glitch && c == 2) begin
        start     = 1'b1;
        datain    = ~d[5:0];
        amount    = 3'd1;
        mode      = 2'(SHIFT);
        direction = ~dir[0];
      end else begin
        start = 1'b0;
      end
      checkOutput("busy_during_op", {7'd0, busy}, 8'd1);
      checkOutput("done_timing", {7'd0, done}, (c == amt + 1) ? 8'd1 : 8'd0);
      if (c == amt + 1) begin
        checkOutput("data_at_done", {2'd0, dataout}, expD[7:0]);
        checkOutput("sout_at_done", {7'd0, serial_out}, expSout[7:0]);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("busy_after", {7'd0, busy}, 8'd0);
    checkOutput("done_after", {7'd0, done}, 8'd0);
    checkOutput("data_hold", {2'd0, dataout}, expD[7:0]);
    checkOutput("sout_hold", {7'd0, serial_out}, expSout[7:0]);
  endtask

  initial begin
    int rd;
    int ra;
    int rm;
    int rdir;
    logic [7:0] rs;

    rst = 1'b1; start = 1'b0; datain = '0; amount = '0; mode = '0;
    direction = 1'b0; serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data", {2'd0, dataout}, 8'd0);
    checkOutput("reset_sout", {7'd0, serial_out}, 8'd0);
    checkOutput("reset_busy", {7'd0, busy}, 8'd0);
    checkOutput("reset_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    expSout = 0;
    @(posedge clk); #1;

    applyStimulus(6'b100101, 2, 1, 1, 8'h00, 1'b0);
    checkOutput("rotl2_const", {2'd0, dataout}, 8'b010110);
    checkOutput("rotl2_sout", {7'd0, serial_out}, 8'd0);

    applyStimulus(6'b100101, 3, 2, 0, 8'h00, 1'b0);
    checkOutput("asr3_const", {2'd0, dataout}, 8'b111100);
    checkOutput("asr3_sout", {7'd0, serial_out}, 8'd1);
    applyStimulus(6'b100101, 7, 2, 0, 8'h00, 1'b0);
    checkOutput("asr7_const", {2'd0, dataout}, 8'b111111);

    applyStimulus(6'b100101, 1, 0, 1, 8'hFF, 1'b0);
    checkOutput("shl1_const", {2'd0, dataout}, 8'b001011);
    checkOutput("shl1_sout", {7'd0, serial_out}, 8'd1);
    applyStimulus(6'b100101, 6, 0, 0, 8'h15, 1'b0);
    checkOutput("shr6_const", {2'd0, dataout}, 8'b010101);

    applyStimulus(6'b110011, 0, 1, 1, 8'hFF, 1'b0);
    checkOutput("amt0_const", {2'd0, dataout}, 8'b110011);

    applyStimulus(6'b101100, 5, 1, 0, 8'h00, 1'b1);

    // Abort mid-operation: reset lands on the edge ending the second RUN cycle.
    start = 1'b1; datain = 6'b111011; amount = 3'd5; mode = 2'(ROTATE); direction = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_data", {2'd0, dataout}, 8'd0);
    checkOutput("abort_sout", {7'd0, serial_out}, 8'd0);
    checkOutput("abort_busy", {7'd0, busy}, 8'd0);
    checkOutput("abort_done", {7'd0, done}, 8'd0);
    rst = 1'b0;
    expSout = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", {7'd0, done}, 8'd0);
    end
    applyStimulus(6'b000111, 3, 0, 1, 8'h05, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rd   = int'($urandom_range(63, 0));
      ra   = int'($urandom_range(7, 0));
      rm   = int'($urandom_range(3, 0));
      rdir = int'($urandom_range(1, 0));
      rs   = 8'($urandom);
      applyStimulus(rd, ra, rm, rdir, rs, 1'b0);
      repeat (int'($urandom_range(2, 0))) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
